// File: rtl/tt_lbt_pkg.sv
// Shared types and the golden loopback response for the loopback-tile tester.
package tt_lbt_pkg;

    localparam int PAT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } lbt_state_t;

    // Loopback tile: low seven outputs mirror in[0], top output is AND of in[7:4]
    function automatic logic [PAT_W-1:0] lbt_expect(input logic [PAT_W-1:0] p);
        return {&p[7:4], {7{p[0]}}};
    endfunction

endpackage

// File: rtl/tt_lbt_golden.sv
// Combinational golden model of the loopback tile response.
module tt_lbt_golden
    import tt_lbt_pkg::*;
(
    input  logic [PAT_W-1:0] pat,
    output logic [PAT_W-1:0] exp_resp
);

    assign exp_resp = lbt_expect(pat);

endmodule

// File: rtl/tt_loopback_tester.sv
// Self-test sequencer: sweeps patterns into the loopback tile and counts response mismatches.
// Optional build macro TT_LBT_STOP_ON_ERR_EN halts the sweep at the first mismatch.
module tt_loopback_tester
    import tt_lbt_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int PAT_LAST   = 255,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] resp_in,
    output logic [PAT_W-1:0] pat_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [PAT_W-1:0] fail_pat
);

    localparam logic [3:0]       SETTLE_RLD = 4'(SETTLE_CYC - 1);
    localparam logic [PAT_W-1:0] PAT_END    = PAT_W'(PAT_LAST);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    lbt_state_t       state;
    logic [3:0]       settle_cnt;
    logic             fail_seen;
    logic [PAT_W-1:0] exp_resp;
    logic             mismatch;
    logic [ERR_W-1:0] err_inc;

    tt_lbt_golden u_golden (
        .pat      (pat_out),
        .exp_resp (exp_resp)
    );

    assign mismatch = (resp_in != exp_resp);
    assign err_inc  = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pat_out    <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            fail_pat   <= '0;
            fail_seen  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (abort) begin
            // Abort beats start and any CHECK update; error history is kept
            state      <= IDLE;
            pat_out    <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SETTLE;
                        pat_out    <= '0;
                        settle_cnt <= SETTLE_RLD;
                        err_cnt    <= '0;
                        fail_pat   <= '0;
                        fail_seen  <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_inc;
                        if (!fail_seen) begin
                            fail_pat  <= pat_out;
                            fail_seen <= 1'b1;
                        end
                    end
`ifdef TT_LBT_STOP_ON_ERR_EN
                    if (mismatch) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else
`endif
                    if (pat_out == PAT_END) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0) && !mismatch;
                    end else begin
                        state      <= SETTLE;
                        pat_out    <= pat_out + PAT_W'(1);
                        settle_cnt <= SETTLE_RLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_loopback_tester.sv
// Directed bench for tt_loopback_tester; exercises TT_LBT_STOP_ON_ERR_EN when it is defined.
module tb_tt_loopback_tester;

    logic       clk = 1'b0;
    logic       rst, start, abort, start2;
    logic [7:0] resp_in, resp2, pat_out, pat2, fail_pat, fail2, gold, gold2;
    logic       busy, done, pass, busy2, done2, pass2;
    logic [7:0] err_cnt;
    logic [2:0] err2;
    int         mode;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    tt_loopback_tester dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .resp_in(resp_in),
        .pat_out(pat_out), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_pat(fail_pat)
    );

    tt_loopback_tester #(.ERR_W(3)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .abort(abort), .resp_in(resp2),
        .pat_out(pat2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_pat(fail2)
    );

    tt_lbt_golden u_gold  (.pat(pat_out), .exp_resp(gold));
    tt_lbt_golden u_gold2 (.pat(pat2),    .exp_resp(gold2));

    // Response source: 0 healthy, 1 bit7 stuck low, 2 inverted, 3 bit0 stuck high
    always_comb begin
        case (mode)
            1:       resp_in = gold & 8'h7F;
            2:       resp_in = ~gold;
            3:       resp_in = gold | 8'h01;
            default: resp_in = gold;
        endcase
    end
    assign resp2 = ~gold2;

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic count_busy(output int cyc);
        cyc = 0;
        while (busy && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic wait_pat(input logic [7:0] p);
        int n = 0;
        while (pat_out !== p && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        checks++; if (pat_out !== 8'h00) begin errors++; $display("FAIL reset_pat got %0h want 0", pat_out); end
        checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, pass}); end
        checks++; if (err_cnt !== 8'h00 || fail_pat !== 8'h00) begin errors++; $display("FAIL reset_err got %0h/%0h want 0/0", err_cnt, fail_pat); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_golden();
        int cyc;
        mode = 0;
        pulse_start();
        count_busy(cyc);
        checks++; if (cyc != 768) begin errors++; $display("FAIL golden_busy_cycles got %0d want 768", cyc); end
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL golden_done_pass got %b%b want 11", done, pass); end
        checks++; if (err_cnt !== 8'h00 || fail_pat !== 8'h00) begin errors++; $display("FAIL golden_err got %0h/%0h want 0/0", err_cnt, fail_pat); end
        checks++; if (pat_out !== 8'hFF) begin errors++; $display("FAIL golden_pat got %0h want ff", pat_out); end
    endtask

    task automatic test_stuck_bit();
        int cyc;
        mode = 1;
        pulse_start();
        count_busy(cyc);
        checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL stuck_done_pass got %b%b want 10", done, pass); end
        checks++; if (err_cnt !== 8'd16) begin errors++; $display("FAIL stuck_err got %0d want 16", err_cnt); end
        checks++; if (fail_pat !== 8'hF0) begin errors++; $display("FAIL stuck_fail_pat got %0h want f0", fail_pat); end
    endtask

    task automatic test_abort();
        mode = 2;
        pulse_start();
        wait_pat(8'h40);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({busy, done} !== 2'b00 || pat_out !== 8'h00) begin errors++; $display("FAIL abort_idle got %b%b/%0h want 00/0", busy, done, pat_out); end
        checks++; if (err_cnt !== 8'd64 || fail_pat !== 8'h00) begin errors++; $display("FAIL abort_kept got %0d/%0h want 64/0", err_cnt, fail_pat); end
        mode = 0;
        pulse_start();
        checks++; if (err_cnt !== 8'h00 || busy !== 1'b1 || pat_out !== 8'h00) begin errors++; $display("FAIL abort_restart got %0d/%b/%0h want 0/1/0", err_cnt, busy, pat_out); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        mode = 2;
        pulse_start();
        wait_pat(8'h80);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({busy, done, pass} !== 3'b000 || pat_out !== 8'h00) begin errors++; $display("FAIL rstmid_state got %b/%0h want 000/0", {busy, done, pass}, pat_out); end
        checks++; if (err_cnt !== 8'h00 || fail_pat !== 8'h00) begin errors++; $display("FAIL rstmid_err got %0h/%0h want 0/0", err_cnt, fail_pat); end
        mode = 0;
        pulse_start();
        checks++; if (pat_out !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_restart got %0h/%b want 0/1", pat_out, busy); end
        repeat (3) @(negedge clk);
        checks++; if (pat_out !== 8'h01) begin errors++; $display("FAIL rstmid_second_pat got %0h want 1", pat_out); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_saturation();
        int n = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        while (busy2 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        checks++; if (done2 !== 1'b1 || pass2 !== 1'b0) begin errors++; $display("FAIL sat_done_pass got %b%b want 10", done2, pass2); end
        checks++; if (err2 !== 3'd7) begin errors++; $display("FAIL sat_err got %0d want 7", err2); end
        checks++; if (fail2 !== 8'h00) begin errors++; $display("FAIL sat_fail_pat got %0h want 0", fail2); end
        start2 = 1'b1;
        abort  = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        abort  = 1'b0;
        checks++; if ({busy2, done2} !== 2'b00 || pat2 !== 8'h00) begin errors++; $display("FAIL start_abort_done got %b%b/%0h want 00/0", busy2, done2, pat2); end
    endtask

    task automatic test_stop_on_err();
        int cyc;
        mode = 3;
        pulse_start();
        count_busy(cyc);
`ifdef TT_LBT_STOP_ON_ERR_EN
        checks++; if (cyc != 3) begin errors++; $display("FAIL stop_cycles got %0d want 3", cyc); end
        checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL stop_done_pass got %b%b want 10", done, pass); end
        checks++; if (err_cnt !== 8'd1 || fail_pat !== 8'h00 || pat_out !== 8'h00) begin errors++; $display("FAIL stop_vals got %0d/%0h/%0h want 1/0/0", err_cnt, fail_pat, pat_out); end
`else
        checks++; if (cyc != 768) begin errors++; $display("FAIL full_cycles got %0d want 768", cyc); end
        checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL full_done_pass got %b%b want 10", done, pass); end
        checks++; if (err_cnt !== 8'd128 || fail_pat !== 8'h00 || pat_out !== 8'hFF) begin errors++; $display("FAIL full_vals got %0d/%0h/%0h want 128/0/ff", err_cnt, fail_pat, pat_out); end
`endif
    endtask

    task automatic test_back_to_back();
        mode = 0;
        pulse_start();
        checks++; if ({busy, done} !== 2'b10 || pat_out !== 8'h00 || err_cnt !== 8'h00) begin errors++; $display("FAIL b2b_restart got %b%b/%0h/%0d want 10/0/0", busy, done, pat_out, err_cnt); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_golden();
        test_stuck_bit();
        test_abort();
        test_reset_mid();
        test_saturation();
        test_stop_on_err();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
